// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the 8-to-3 priority encoder and its 3-to-8 decoder sibling.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package encoder_pkg;

    // Number of request lines and the width of the encoded index.
    localparam int N  = 8;
    localparam int W  = 3;
    // Width of a population count of an N-bit vector (0..8 needs 4 bits).
    localparam int CW = 4;

    typedef logic [N-1:0]  vec_t;
    typedef logic [W-1:0]  code_t;
    typedef logic [CW-1:0] cnt_t;

    // Index of the highest set bit; bit 7 has the highest priority.
    // An all-zero vector yields 0, so callers must qualify it with |v.
    function automatic code_t prio_idx(input vec_t v);
        code_t r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r = code_t'(i);
            end
        end
        return r;
    endfunction

    // Number of set bits in an 8-bit vector, 0..8.
    function automatic cnt_t popcnt8(input vec_t v);
        cnt_t c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/encoder_8_3_pending_if.sv
// Request/handshake bundle between the pending encoder and its consumer.
// Latency: none (wiring only).
// Backpressure: consumer holds ready low to freeze the offered code.
//
// Signals:
//   req      requester -> encoder  level request lines
//   ready    consumer  -> encoder  accept the offered code
//   valid    encoder   -> consumer code is meaningful
//   code     encoder   -> consumer index of the offered request
//   pending  encoder   -> status   sticky pending register
//   pend_cnt encoder   -> status   popcount of pending
interface encoder_8_3_pending_if
    import encoder_pkg::*;
();
    vec_t  req;
    logic  ready;
    logic  valid;
    code_t code;
    vec_t  pending;
    cnt_t  pend_cnt;

    // Encoder side.
    modport master (
        input  req,
        input  ready,
        output valid,
        output code,
        output pending,
        output pend_cnt
    );

    // Requester/consumer side.
    modport slave (
        output req,
        output ready,
        input  valid,
        input  code,
        input  pending,
        input  pend_cnt
    );

endinterface

// File: rtl/prio_enc_8_3.sv
// Combinational 8-to-3 priority encoder, bit 7 highest priority.
// Latency: zero cycles (pure combinational).
// Backpressure: none; any qualifies idx (idx is 0 when nothing is set).
//
// Ports:
//   vec  in  8-bit vector to encode
//   idx  out index of the highest set bit
//   any  out at least one bit of vec is set
module prio_enc_8_3
    import encoder_pkg::*;
(
    input  vec_t  vec,
    output code_t idx,
    output logic  any
);

    assign idx = prio_idx(vec);
    assign any = |vec;

endmodule

// File: rtl/encoder_8_3_pending.sv
// Sequential 8-to-3 priority encoder: rising edges on req become sticky pending bits,
// latency: a rise sampled at edge k sets pending at edge k and is offered from edge k+1,
// backpressure: valid & ~ready freezes code/valid and nothing leaves pending meanwhile.
//
// Ports:
//   clk  system clock, all state on its rising edge
//   rst  asynchronous active-high reset
//   bus  master modport: req/ready in; valid/code/pending/pend_cnt out
module encoder_8_3_pending
    import encoder_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    encoder_8_3_pending_if.master       bus
);

    vec_t  req_q;
    vec_t  pend_q;
    vec_t  pend_nxt;
    vec_t  rise;
    vec_t  take;
    logic  valid_q;
    code_t code_q;
    cnt_t  cnt_q;

    code_t top_idx;
    logic  top_any;
    logic  slot_free;
    logic  load;

    // One event per 0->1 transition. req_q clears on reset, so a line
    // already high when reset releases is seen as a rise on the first edge.
    assign rise = bus.req & ~req_q;

    prio_enc_8_3 u_prio (
        .vec (pend_q),
        .idx (top_idx),
        .any (top_any)
    );

    // The slot can take a new code when it is empty or being accepted now.
    assign slot_free = ~valid_q | bus.ready;
    assign load      = slot_free & top_any;

    always_comb begin
        take = '0;
        if (load) begin
            take[top_idx] = 1'b1;
        end
    end

    // A fresh rise on the bit being taken keeps it pending, so the same
    // index is offered again later rather than being lost.
    assign pend_nxt = rise | (pend_q & ~take);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            req_q  <= bus.req;
            pend_q <= pend_nxt;
            // Counting the next-state vector keeps pend_cnt in step with pending.
            cnt_q  <= popcnt8(pend_nxt);
            if (slot_free) begin
                valid_q <= top_any;
                // code keeps its last value when the slot empties.
                if (top_any) begin
                    code_q <= top_idx;
                end
            end
        end
    end

    assign bus.valid    = valid_q;
    assign bus.code     = code_q;
    assign bus.pending  = pend_q;
    assign bus.pend_cnt = cnt_q;

endmodule

// File: tb/tb_encoder_8_3_pending.sv
module tb_encoder_8_3_pending;
    import encoder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    encoder_8_3_pending_if bus ();

    encoder_8_3_pending dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_req_q   = 8'h00;
    logic [7:0] m_pend    = 8'h00;
    logic       m_valid   = 1'b0;
    logic [2:0] m_code    = 3'd0;

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [7:0] rise;
        int         h;
        if (rst) begin
            m_req_q = 8'h00;
            m_pend  = 8'h00;
            m_valid = 1'b0;
            m_code  = 3'd0;
        end else begin
            rise    = bus.req & ~m_req_q;
            m_req_q = bus.req;
            if (!m_valid || bus.ready) begin
                h = highest(m_pend);
                if (h >= 0) begin
                    m_code  = h[2:0];
                    m_valid = 1'b1;
                    m_pend[h] = 1'b0;
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_pend = m_pend | rise;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("cyc_valid", 32'(bus.valid), 32'(m_valid));
            chk("cyc_code", 32'(bus.code), 32'(m_code));
            chk("cyc_pending", 32'(bus.pending), 32'(m_pend));
            chk("cyc_pend_cnt", 32'(bus.pend_cnt), 32'($countones(m_pend)));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [2:0] c,
                           input logic [7:0] p, input logic [3:0] n);
        chk({name, "_valid"}, 32'(bus.valid), 32'(v));
        chk({name, "_code"}, 32'(bus.code), 32'(c));
        chk({name, "_pending"}, 32'(bus.pending), 32'(p));
        chk({name, "_cnt"}, 32'(bus.pend_cnt), 32'(n));
    endtask

    initial begin
        bus.req   = 8'hFF;
        bus.ready = 1'b1;
        rst       = 1'b1;

        // Reset held with all requests high.
        tick();
        chk_out("reset", 1'b0, 3'd0, 8'h00, 4'd0);
        #4 rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk_out("rel_load", 1'b0, 3'd0, 8'hFF, 4'd8);
        tick();
        chk_out("rel_first", 1'b1, 3'd7, 8'h7F, 4'd7);
        tick(7);
        chk_out("rel_last", 1'b1, 3'd0, 8'h00, 4'd0);
        tick();
        chk("rel_idle_valid", 32'(bus.valid), 32'd0);

        // Single request held high.
        bus.req = 8'h00;
        tick(2);
        bus.req = 8'h04;
        tick();
        chk_out("single_load", 1'b0, 3'd0, 8'h04, 4'd1);
        tick();
        chk_out("single_offer", 1'b1, 3'd2, 8'h00, 4'd0);
        tick();
        chk_out("single_done", 1'b0, 3'd2, 8'h00, 4'd0);
        tick(2);
        chk("single_once", 32'(bus.valid), 32'd0);

        // Priority drain of 8'hA5.
        bus.req = 8'h00;
        tick();
        bus.req = 8'hA5;
        tick();
        chk_out("drain_load", 1'b0, 3'd2, 8'hA5, 4'd4);
        tick();
        chk_out("drain_7", 1'b1, 3'd7, 8'h25, 4'd3);
        tick();
        chk_out("drain_5", 1'b1, 3'd5, 8'h05, 4'd2);
        tick();
        chk_out("drain_2", 1'b1, 3'd2, 8'h01, 4'd1);
        tick();
        chk_out("drain_0", 1'b1, 3'd0, 8'h00, 4'd0);
        tick();
        chk("drain_end_valid", 32'(bus.valid), 32'd0);

        // Backpressure: code 3 held while bit 6 arrives.
        bus.req   = 8'h00;
        tick();
        bus.ready = 1'b0;
        bus.req   = 8'h08;
        tick(2);
        chk_out("bp_offer3", 1'b1, 3'd3, 8'h00, 4'd0);
        bus.req = 8'h48;
        tick();
        chk_out("bp_hold", 1'b1, 3'd3, 8'h40, 4'd1);
        tick(2);
        chk_out("bp_hold2", 1'b1, 3'd3, 8'h40, 4'd1);
        bus.ready = 1'b1;
        tick();
        chk_out("bp_6", 1'b1, 3'd6, 8'h00, 4'd0);
        tick();
        chk("bp_end_valid", 32'(bus.valid), 32'd0);

        // Set wins over take on bit 4.
        bus.req   = 8'h00;
        tick();
        bus.ready = 1'b0;
        bus.req   = 8'h08;
        tick(2);
        bus.req = 8'h18;
        tick();
        chk_out("sw_pend4", 1'b1, 3'd3, 8'h10, 4'd1);
        bus.req = 8'h08;
        tick();
        bus.req   = 8'h18;
        bus.ready = 1'b1;
        tick();
        chk_out("sw_take", 1'b1, 3'd4, 8'h10, 4'd1);
        tick();
        chk_out("sw_again", 1'b1, 3'd4, 8'h00, 4'd0);
        tick();

        // Asynchronous reset mid-transfer.
        bus.req   = 8'h00;
        tick();
        bus.ready = 1'b0;
        bus.req   = 8'h20;
        tick(2);
        bus.req = 8'h32;
        tick();
        chk_out("ar_before", 1'b1, 3'd5, 8'h12, 4'd2);
        #1 rst = 1'b1;
        #1;
        chk_out("ar_async", 1'b0, 3'd0, 8'h00, 4'd0);
        tick();
        rst       = 1'b0;
        bus.ready = 1'b1;
        tick();

        // Randomized traffic with sparse toggles and random backpressure.
        for (int c = 0; c < 3000; c++) begin
            bus.req   = bus.req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            bus.ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
